// File: rtl/store_rmw_sequencer.sv
// Read-modify-write sequencer for SB/SH/SW stores on a word-wide single-port RAM.
// Drives an external combinational merge unit and handles stores that straddle two words.
module store_rmw_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_st_valid,
    output logic              o_st_ready,
    input  logic [2:0]        i_st_funct3,
    input  logic [ADDR_W-1:0] i_st_addr,
    input  logic [31:0]       i_st_data,
    output logic              o_st_done,
    output logic              o_st_err,
    output logic [ADDR_W-3:0] o_mem_addr,
    output logic              o_mem_re,
    output logic              o_mem_we,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    output logic [2:0]        o_su_funct3,
    output logic [1:0]        o_su_addr,
    output logic [31:0]       o_su_mem1,
    output logic [31:0]       o_su_mem2,
    output logic [31:0]       o_su_data,
    input  logic [31:0]       i_su_data_1,
    input  logic [31:0]       i_su_data_2
);
    localparam int WA = ADDR_W - 2;

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_CAP, S_WR0, S_WR1, S_DONE
    } state_t;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [1:0]  off;
        logic [31:0] data;
    } req_t;

    state_t          r_state, w_next;
    req_t            r_req;
    logic [31:0]     r_mem1, r_mem2;
    logic [WA-1:0]   r_w0, r_w1;
    logic            r_cross;
    logic            r_err;
    logic [WA-1:0]   r_addr_hold;
    logic [31:0]     r_wdata_hold;

    logic            w_accept, w_legal, w_cross_in, w_full_in;
    logic            w_re, w_we;
    logic [WA-1:0]   w_w0_in, w_addr;
    logic [31:0]     w_wdata;

    assign w_accept   = i_st_valid && (r_state == S_IDLE);
    assign w_legal    = (i_st_funct3 == 3'b000) || (i_st_funct3 == 3'b001) ||
                        (i_st_funct3 == 3'b010);
    assign w_cross_in = ((i_st_funct3 == 3'b001) && (i_st_addr[1:0] == 2'b11)) ||
                        ((i_st_funct3 == 3'b010) && (i_st_addr[1:0] != 2'b00));
    assign w_full_in  = (i_st_funct3 == 3'b010) && (i_st_addr[1:0] == 2'b00);
    assign w_w0_in    = i_st_addr[ADDR_W-1:2];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_legal) w_next = w_full_in ? S_WR0 : S_RD0;
            S_RD0:  w_next = r_cross ? S_RD1 : S_CAP;
            S_RD1:  w_next = S_CAP;
            S_CAP:  w_next = S_WR0;
            S_WR0:  w_next = r_cross ? S_WR1 : S_DONE;
            S_WR1:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Write data comes straight from the merge unit: for straddling stores the
    // second old word only lands in the CAP cycle, so it cannot be pre-registered.
    always_comb begin
        w_re    = (r_state == S_RD0) || (r_state == S_RD1);
        w_we    = (r_state == S_WR0) || (r_state == S_WR1);
        w_addr  = r_addr_hold;
        w_wdata = r_wdata_hold;
        if (w_re || w_we)
            w_addr = ((r_state == S_RD1) || (r_state == S_WR1)) ? r_w1 : r_w0;
        if (w_we)
            w_wdata = (r_state == S_WR1) ? i_su_data_2 : i_su_data_1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req        <= '0;
            r_mem1       <= '0;
            r_mem2       <= '0;
            r_w0         <= '0;
            r_w1         <= '0;
            r_cross      <= 1'b0;
            r_err        <= 1'b0;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else begin
            r_err        <= w_accept && !w_legal;
            r_addr_hold  <= w_addr;
            r_wdata_hold <= w_wdata;
            if (w_accept && w_legal) begin
                r_req.funct3 <= i_st_funct3;
                r_req.off    <= i_st_addr[1:0];
                r_req.data   <= i_st_data;
                r_w0         <= w_w0_in;
                r_w1         <= w_w0_in + WA'(1);
                r_cross      <= w_cross_in;
                r_mem1       <= '0;
                r_mem2       <= '0;
            end
            if (r_state == S_RD1)
                r_mem1 <= i_mem_rdata;
            if (r_state == S_CAP) begin
                if (r_cross) r_mem2 <= i_mem_rdata;
                else         r_mem1 <= i_mem_rdata;
            end
        end
    end

    assign o_st_ready  = (r_state == S_IDLE);
    assign o_st_done   = (r_state == S_DONE);
    assign o_st_err    = r_err;
    assign o_mem_re    = w_re;
    assign o_mem_we    = w_we;
    assign o_mem_addr  = w_addr;
    assign o_mem_wdata = w_wdata;
    assign o_su_funct3 = r_req.funct3;
    assign o_su_addr   = r_req.off;
    assign o_su_data   = r_req.data;
    assign o_su_mem1   = r_mem1;
    assign o_su_mem2   = r_mem2;

    a_no_re_we: assert property (@(posedge i_clk) disable iff (i_rst) !(w_re && w_we));

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Directed bench for store_rmw_sequencer: behavioural RAM, byte-lane merge unit,
// a table of single stores and hand sequences for reset-abort and illegal funct3.
module tb_store_rmw_sequencer;
    logic        clk, rst;
    logic        st_valid, st_ready;
    logic [2:0]  st_f3;
    logic [31:0] st_addr, st_data;
    logic        st_done, st_err;
    logic [29:0] mem_addr;
    logic        mem_re, mem_we;
    logic [31:0] mem_wdata, mem_rdata;
    logic [2:0]  su_f3;
    logic [1:0]  su_addr;
    logic [31:0] su_mem1, su_mem2, su_data, su_d1, su_d2;

    int tests = 0;
    int fails = 0;

    store_rmw_sequencer #(.ADDR_W(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_st_valid(st_valid), .o_st_ready(st_ready),
        .i_st_funct3(st_f3), .i_st_addr(st_addr), .i_st_data(st_data),
        .o_st_done(st_done), .o_st_err(st_err),
        .o_mem_addr(mem_addr), .o_mem_re(mem_re), .o_mem_we(mem_we),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_su_funct3(su_f3), .o_su_addr(su_addr), .o_su_mem1(su_mem1),
        .o_su_mem2(su_mem2), .o_su_data(su_data),
        .i_su_data_1(su_d1), .i_su_data_2(su_d2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Merge unit: insert the sized, byte-shifted store into the 64-bit {W1,W0} window.
    function automatic logic [63:0] merge(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] d, input logic [31:0] m1,
                                          input logic [31:0] m2);
        logic [63:0] mask, ins;
        mask = (f3 == 3'b000) ? 64'hFF : (f3 == 3'b001) ? 64'hFFFF : 64'hFFFF_FFFF;
        ins  = ({32'd0, d} & mask) << (8 * off);
        mask = mask << (8 * off);
        return ({m2, m1} & ~mask) | ins;
    endfunction

    always_comb begin
        {su_d2, su_d1} = merge(su_f3, su_addr, su_data, su_mem1, su_mem2);
    end

    // RAM model indexed by the low 8 word-address bits; preloads share the write port.
    logic [31:0] ram [256];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;
    logic [29:0] rd_log[$];
    logic [29:0] wr_log_a[$];
    logic [31:0] wr_log_d[$];

    always @(posedge clk) begin
        if (pl_en) ram[pl_idx] <= pl_data;
        if (mem_re) begin
            mem_rdata <= ram[mem_addr[7:0]];
            rd_log.push_back(mem_addr);
        end
        if (mem_we) begin
            ram[mem_addr[7:0]] <= mem_wdata;
            wr_log_a.push_back(mem_addr);
            wr_log_d.push_back(mem_wdata);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [29:0] w, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = w[7:0]; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] init0, init1;
        bit          err;
        int          lat, nrd, nwr;
        logic [31:0] m0, m1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] i0, input logic [31:0] i1, input bit e,
                       input int lat, input int nrd, input int nwr,
                       input logic [31:0] m0, input logic [31:0] m1);
        vec_t v;
        v.f3 = f3; v.addr = a; v.data = d; v.init0 = i0; v.init1 = i1; v.err = e;
        v.lat = lat; v.nrd = nrd; v.nwr = nwr; v.m0 = m0; v.m1 = m1;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        logic [29:0] w0, w1;
        int rb, wb, lat;
        bit overlap;
        string p;
        p  = $sformatf("v%0d", id);
        w0 = v.addr[31:2];
        w1 = w0 + 30'd1;
        preload(w0, v.init0);
        preload(w1, v.init1);
        chk({p, " ready_idle"}, 64'(st_ready), 64'd1);
        rb = rd_log.size();
        wb = wr_log_a.size();
        st_valid = 1'b1; st_f3 = v.f3; st_addr = v.addr; st_data = v.data;
        @(negedge clk);
        st_valid = 1'b0; st_f3 = 3'b000; st_addr = 32'hFFFF_FFFF; st_data = 32'h0;
        overlap = mem_re && mem_we;
        lat = 1;
        if (v.err) begin
            chk({p, " err_pulse"}, 64'(st_err), 64'd1);
            chk({p, " err_ready"}, 64'(st_ready), 64'd1);
            chk({p, " err_memacc"}, 64'({mem_re, mem_we}), 64'd0);
            @(negedge clk);
            chk({p, " err_onecyc"}, 64'(st_err), 64'd0);
            repeat (4) begin
                @(negedge clk);
                if (st_done || mem_re || mem_we) overlap = 1'b1;
            end
            chk({p, " err_quiet"}, 64'(overlap), 64'd0);
        end else begin
            chk({p, " busy"}, 64'(st_ready), 64'd0);
            while (!st_done && lat < 20) begin
                @(negedge clk);
                lat++;
                if (mem_re && mem_we) overlap = 1'b1;
            end
            chk({p, " latency"}, 64'(lat), 64'(v.lat));
            chk({p, " re_we_excl"}, 64'(overlap), 64'd0);
            chk({p, " ready_in_done"}, 64'(st_ready), 64'd0);
            chk({p, " su_data"}, 64'(su_data), 64'(v.data));
            chk({p, " su_addr"}, 64'(su_addr), 64'(v.addr[1:0]));
            if (v.nrd < 2) chk({p, " su_mem2_zero"}, 64'(su_mem2), 64'd0);
            if (v.nrd == 0) chk({p, " su_mem1_zero"}, 64'(su_mem1), 64'd0);
            @(negedge clk);
        end
        chk({p, " nrd"}, 64'(rd_log.size() - rb), 64'(v.nrd));
        chk({p, " nwr"}, 64'(wr_log_a.size() - wb), 64'(v.nwr));
        if (v.nrd >= 1 && rd_log.size() > rb)     chk({p, " rd0_addr"}, 64'(rd_log[rb]), 64'(w0));
        if (v.nrd == 2 && rd_log.size() > rb + 1) chk({p, " rd1_addr"}, 64'(rd_log[rb+1]), 64'(w1));
        if (v.nwr >= 1 && wr_log_a.size() > wb) begin
            chk({p, " wr0_addr"}, 64'(wr_log_a[wb]), 64'(w0));
            chk({p, " wr0_data"}, 64'(wr_log_d[wb]), 64'(v.m0));
        end
        if (v.nwr == 2 && wr_log_a.size() > wb + 1) begin
            chk({p, " wr1_addr"}, 64'(wr_log_a[wb+1]), 64'(w1));
            chk({p, " wr1_data"}, 64'(wr_log_d[wb+1]), 64'(v.m1));
        end
        chk({p, " ram_w0"}, 64'(ram[w0[7:0]]), 64'(v.m0));
        chk({p, " ram_w1"}, 64'(ram[w1[7:0]]), 64'(v.m1));
    endtask

    initial begin
        int wb, k;
        bit hit;
        rst = 1'b1; st_valid = 1'b0; st_f3 = 3'b000; st_addr = '0; st_data = '0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;

        //   f3    addr          data          init0         init1         err lat rd wr  m0            m1
        add(3'd2, 32'h100,      32'hDEADBEEF, 32'h12345678, 32'h9ABCDEF0, 0, 2, 0, 1, 32'hDEADBEEF, 32'h9ABCDEF0);
        add(3'd0, 32'h102,      32'h123456AA, 32'h11223344, 32'h55667788, 0, 4, 1, 1, 32'h11AA3344, 32'h55667788);
        add(3'd2, 32'h103,      32'hCAFEBABE, 32'h11223344, 32'h55667788, 0, 6, 2, 2, 32'hBE223344, 32'h55CAFEBA);
        add(3'd1, 32'hFFFFFFFF, 32'h0000BEEF, 32'hA1B2C3D4, 32'h01020304, 0, 6, 2, 2, 32'hEFB2C3D4, 32'h010203BE);
        add(3'd1, 32'h202,      32'hFFFF1234, 32'hAABBCCDD, 32'h11111111, 0, 4, 1, 1, 32'h1234CCDD, 32'h11111111);
        add(3'd1, 32'h201,      32'h0000ABCD, 32'hAABBCCDD, 32'h11111111, 0, 4, 1, 1, 32'hAAABCDDD, 32'h11111111);
        add(3'd0, 32'h303,      32'h00000077, 32'h01020304, 32'h05060708, 0, 4, 1, 1, 32'h77020304, 32'h05060708);
        add(3'd2, 32'h301,      32'h11223344, 32'hAAAAAAAA, 32'hBBBBBBBB, 0, 6, 2, 2, 32'h223344AA, 32'hBBBBBB11);
        add(3'd2, 32'h302,      32'h11223344, 32'hAAAAAAAA, 32'hBBBBBBBB, 0, 6, 2, 2, 32'h3344AAAA, 32'hBBBB1122);
        add(3'd0, 32'h000,      32'h0000005A, 32'hFFFFFFFF, 32'hEEEEEEEE, 0, 4, 1, 1, 32'hFFFFFF5A, 32'hEEEEEEEE);
        add(3'd3, 32'h100,      32'hDEADBEEF, 32'h01010101, 32'h02020202, 1, 0, 0, 0, 32'h01010101, 32'h02020202);
        add(3'd2, 32'h100,      32'h0BADF00D, 32'h01010101, 32'h02020202, 0, 2, 0, 1, 32'h0BADF00D, 32'h02020202);
        add(3'd7, 32'h203,      32'h12345678, 32'h33333333, 32'h44444444, 1, 0, 0, 0, 32'h33333333, 32'h44444444);

        // Reset values
        @(negedge clk);
        chk("rst ready", 64'(st_ready), 64'd1);
        chk("rst strobes", 64'({st_done, st_err, mem_re, mem_we}), 64'd0);
        chk("rst mem_addr", 64'(mem_addr), 64'd0);
        chk("rst mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst su", {su_f3, su_addr, su_mem1, su_mem2 | su_data}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Reset asserted in WR1 of a straddling SW: W0 committed, W1 untouched
        preload(30'h40, 32'h11223344);
        preload(30'h41, 32'h55667788);
        wb = wr_log_a.size();
        st_valid = 1'b1; st_f3 = 3'd2; st_addr = 32'h103; st_data = 32'hCAFEBABE;
        @(negedge clk);
        st_valid = 1'b0;
        hit = 1'b0;
        k = 0;
        while (!hit && k < 20) begin
            if (mem_we && mem_addr == 30'h41) hit = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk("abort reached_wr1", 64'(hit), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort ready", 64'(st_ready), 64'd1);
        chk("abort strobes", 64'({st_done, st_err, mem_re, mem_we}), 64'd0);
        chk("abort mem_addr", 64'(mem_addr), 64'd0);
        chk("abort mem_wdata", 64'(mem_wdata), 64'd0);
        chk("abort su", {su_mem1, su_mem2 | su_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort ready_after", 64'(st_ready), 64'd1);
        chk("abort nwr", 64'(wr_log_a.size() - wb), 64'd1);
        chk("abort ram_w0", 64'(ram[8'h40]), 64'hBE223344);
        chk("abort ram_w1", 64'(ram[8'h41]), 64'h55667788);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
